// File: rtl/shift_ser_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_ser_ctrl : sequences a left-shift register as an MSB-first         |
// |                  parallel-to-serial transmitter with per-word bit period. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module shift_ser_ctrl #(
  parameter int   DW    = 4,
  parameter int   DIV_W = 8,
  parameter logic FILL  = 1'b0
) (
  input  logic                   clk,
  input  logic                   sync_rst,
  input  logic                   in_valid,
  input  logic [DW-1:0]          in_data,
  output logic                   in_ready,
  input  logic [DIV_W-1:0]       div,
  input  logic                   abort,
  output logic                   sr_load,
  output logic                   sr_en,
  output logic [DW-1:0]          sr_data,
  output logic                   sr_data_l,
  input  logic [DW-1:0]          sr_q,
  output logic                   ser_bit,
  output logic                   bit_vld,
  output logic [$clog2(DW)-1:0]  bit_idx,
  output logic                   busy,
  output logic                   done
);

  localparam int IW = $clog2(DW);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(DW - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q,   state_d;
  logic [DIV_W-1:0] pcnt_q,    pcnt_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic             done_q,    done_d;

  logic w_period_end;
  logic w_last_bit;
  logic w_unused_sr_q;

  assign w_period_end = (pcnt_q == div_q);
  assign w_last_bit   = (bit_idx_q == C_LAST_IDX);

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;
    in_ready  = 1'b0;
    sr_load   = 1'b0;
    sr_en     = 1'b0;
    busy      = 1'b0;
    bit_vld   = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = ~sync_rst;
        if (in_valid && !sync_rst) begin
          sr_load   = 1'b1;
          div_d     = div;
          pcnt_d    = '0;
          bit_idx_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy    = ~sync_rst;
        bit_vld = ~sync_rst;
        // Abort wins over period completion so no stray shift happens.
        if (abort) begin
          state_d = S_IDLE;
        end else if (w_period_end) begin
          pcnt_d = '0;
          if (w_last_bit) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            sr_en     = ~sync_rst;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q   <= S_IDLE;
      pcnt_q    <= '0;
      div_q     <= '0;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
    end
  end

  assign sr_data   = in_data;
  assign sr_data_l = FILL;
  assign ser_bit   = sr_q[DW-1];
  assign bit_idx   = bit_idx_q;
  assign done      = done_q;

  // Only the MSB of the register is observed; lower bits are held by the register itself.
  assign w_unused_sr_q = ^sr_q[DW-2:0];

endmodule
`default_nettype wire
